// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the memory arbiter: FSM state
//                encoding, owner codes and default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_LD  = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_LD   = 2'b10;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the processor, program-loader and memory-side
//                signals of the memory arbiter. The slave modport is the
//                arbiter's view; master is the view of the surrounding system.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic          cpu_req;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;

    logic          ld_req;
    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_ack;

    logic [DW-1:0] rdata;
    logic [1:0]    owner;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  ld_req, ld_wr, ld_addr, ld_wdata,
        input  mem_rdata,
        output cpu_ack, ld_ack, rdata, owner,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output ld_req, ld_wr, ld_addr, ld_wdata,
        output mem_rdata,
        input  cpu_ack, ld_ack, rdata, owner,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester (processor / program loader) arbiter for a
//                single-port memory. One access at a time: grant, LAT memory
//                cycles, one acknowledge cycle, back to idle.
//                Build option ARB_ROUND_ROBIN_EN: on simultaneous requests the
//                requester not granted last wins (processor wins the first
//                tie). Without it the processor always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int LAT = 1
) (
    input wire           Clock,
    input wire           Reset,
    mem_arbiter_if.slave bus
);

    // Final value of the per-access cycle counter (counts 0..LAT-1).
    localparam logic [3:0] c_cnt_last = 4'(LAT - 1);

`ifdef ARB_ROUND_ROBIN_EN
    // Last owner starts as the loader so the processor wins the first tie.
    localparam logic c_srv_ld_rst = 1'b1;
`else
    localparam logic c_srv_ld_rst = 1'b0;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic          r_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    // Requester of the current/most recent access: selects which ack pulses
    // and, in round-robin builds, doubles as the last-owner record.
    logic          r_srv_ld;

    logic          w_grant_cpu;
    logic          w_grant_ld;
    logic          w_cpu_wins;
    logic          w_in_gnt;
    logic          w_cnt_last;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_cpu_wins = bus.cpu_req && (!bus.ld_req || r_srv_ld);
`else
    assign w_cpu_wins = bus.cpu_req;
`endif

    assign w_in_gnt   = (r_state == GNT_CPU) || (r_state == GNT_LD);
    assign w_cnt_last = (r_cnt == c_cnt_last);

    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    // State register; reset drops straight back to idle, aborting any access.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, grant strobes and per-state memory/handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_cpu = 1'b0;
        w_grant_ld  = 1'b0;
        bus.mem_en  = 1'b0;
        bus.mem_we  = 1'b0;
        bus.owner   = OWN_NONE;
        bus.cpu_ack = 1'b0;
        bus.ld_ack  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cpu_wins) begin
                    w_grant_cpu = 1'b1;
                    w_state_nxt = GNT_CPU;
                end else if (bus.ld_req) begin
                    w_grant_ld  = 1'b1;
                    w_state_nxt = GNT_LD;
                end
            end
            GNT_CPU: begin
                bus.mem_en = 1'b1;
                bus.mem_we = r_wr;
                bus.owner  = OWN_CPU;
                if (w_cnt_last) begin
                    w_state_nxt = ACK;
                end
            end
            GNT_LD: begin
                bus.mem_en = 1'b1;
                bus.mem_we = r_wr;
                bus.owner  = OWN_LD;
                if (w_cnt_last) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                bus.cpu_ack = !r_srv_ld;
                bus.ld_ack  = r_srv_ld;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's command on grant and pace the access with the counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cnt    <= 4'd0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_srv_ld <= c_srv_ld_rst;
        end else if (w_grant_cpu) begin
            r_cnt    <= 4'd0;
            r_wr     <= bus.cpu_wr;
            r_addr   <= bus.cpu_addr;
            r_wdata  <= bus.cpu_wdata;
            r_srv_ld <= 1'b0;
        end else if (w_grant_ld) begin
            r_cnt    <= 4'd0;
            r_wr     <= bus.ld_wr;
            r_addr   <= bus.ld_addr;
            r_wdata  <= bus.ld_wdata;
            r_srv_ld <= 1'b1;
        end else if (w_in_gnt && !w_cnt_last) begin
            r_cnt    <= r_cnt + 4'd1;
        end
    end

    // Capture read data at the end of the last memory cycle of a read.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_rdata <= '0;
        end else if (w_in_gnt && w_cnt_last && !r_wr) begin
            r_rdata <= bus.mem_rdata;
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios
//                followed by randomized requests and resets, compared every
//                cycle against a timestamp-based transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int LAT = 3;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // Simple read-only memory image behind the arbiter.
    logic [DW-1:0] memarr [0:31];
    assign bus.mem_rdata = memarr[bus.mem_addr];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model ----------------
    // An access granted at the edge ending idle cycle g occupies cycles
    // g+1..g+LAT on the memory and acknowledges in cycle g+LAT+1.
    bit            m_busy    = 1'b0;
    int            m_gcyc    = 0;
    bit            m_ld      = 1'b0;
    bit            m_wr      = 1'b0;
    logic [AW-1:0] m_addr    = '0;
    logic [DW-1:0] m_wdata   = '0;
    logic [DW-1:0] m_rdata   = '0;
    bit            m_last_ld = 1'b1;

    always @(posedge Clock) begin
        int  ph;
        bit  pick_ld;
        if (!Reset) begin
            m_busy    = 1'b0;
            m_rdata   = '0;
            m_addr    = '0;
            m_wdata   = '0;
            m_wr      = 1'b0;
            m_last_ld = 1'b1;
        end else if (m_busy) begin
            ph = cyc - m_gcyc;
            if (ph == LAT && !m_wr) m_rdata = memarr[m_addr];
            if (ph == LAT + 1) m_busy = 1'b0;
        end else if (bus.cpu_req || bus.ld_req) begin
            if (bus.cpu_req && bus.ld_req) pick_ld = RR ? !m_last_ld : 1'b0;
            else                           pick_ld = bus.ld_req;
            m_busy    = 1'b1;
            m_gcyc    = cyc;
            m_ld      = pick_ld;
            m_last_ld = pick_ld;
            m_wr      = pick_ld ? bus.ld_wr    : bus.cpu_wr;
            m_addr    = pick_ld ? bus.ld_addr  : bus.cpu_addr;
            m_wdata   = pick_ld ? bus.ld_wdata : bus.cpu_wdata;
        end
        cyc++;
    end

    // Compare every output against the model each cycle.
    always @(negedge Clock) begin
        int         ph;
        logic       e_en, e_we, e_cack, e_lack;
        logic [1:0] e_own;
        ph     = cyc - m_gcyc;
        e_en   = Reset && m_busy && ph >= 1 && ph <= LAT;
        e_we   = e_en && m_wr;
        e_own  = !e_en ? OWN_NONE : (m_ld ? OWN_LD : OWN_CPU);
        e_cack = Reset && m_busy && ph == LAT + 1 && !m_ld;
        e_lack = Reset && m_busy && ph == LAT + 1 && m_ld;
        check("mem_en",    32'(bus.mem_en),    32'(e_en));
        check("mem_we",    32'(bus.mem_we),    32'(e_we));
        check("owner",     32'(bus.owner),     32'(e_own));
        check("cpu_ack",   32'(bus.cpu_ack),   32'(e_cack));
        check("ld_ack",    32'(bus.ld_ack),    32'(e_lack));
        check("rdata",     32'(bus.rdata),     Reset ? 32'(m_rdata) : 32'd0);
        check("mem_addr",  32'(bus.mem_addr),  Reset ? 32'(m_addr)  : 32'd0);
        check("mem_wdata", 32'(bus.mem_wdata), Reset ? 32'(m_wdata) : 32'd0);
    end

    // ---------------- activity monitor for directed checks ----------------
    int         n_en = 0, n_we = 0, n_cack = 0, n_lack = 0;
    logic [AW-1:0] last_we_addr = '0;
    logic [1:0] prev_owner = OWN_NONE;
    logic [1:0] grants [$];

    always @(negedge Clock) begin
        if (bus.mem_en) n_en++;
        if (bus.mem_we) begin
            n_we++;
            last_we_addr = bus.mem_addr;
        end
        if (bus.cpu_ack) n_cack++;
        if (bus.ld_ack)  n_lack++;
        if (bus.owner != OWN_NONE && prev_owner == OWN_NONE) grants.push_back(bus.owner);
        prev_owner = bus.owner;
    end

    task automatic wait_ack(input bit ld, input int max, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int k = 0; k < max; k++) begin
            @(negedge Clock);
            if (ld ? bus.ld_ack : bus.cpu_ack) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_owner(input logic [1:0] o, input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge Clock);
            if (bus.owner == o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_req(input bit ld, input bit acked);
        logic          req, wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            r;
        req  = ld ? bus.ld_req   : bus.cpu_req;
        wr   = ld ? bus.ld_wr    : bus.cpu_wr;
        addr = ld ? bus.ld_addr  : bus.cpu_addr;
        wd   = ld ? bus.ld_wdata : bus.cpu_wdata;
        r    = int'($urandom_range(0, 15));
        if ((req && acked) || (!req && r < 8)) begin
            req  = !req || (r < 5);
            wr   = 1'($urandom);
            addr = AW'($urandom);
            wd   = DW'($urandom);
        end else if (req && r == 0) begin
            req = 1'b0;
        end else if (req && r < 5) begin
            wr   = 1'($urandom);
            addr = AW'($urandom);
            wd   = DW'($urandom);
        end
        if (ld) begin
            bus.ld_req = req; bus.ld_wr = wr; bus.ld_addr = addr; bus.ld_wdata = wd;
        end else begin
            bus.cpu_req = req; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit         ok, ca, la;
        int         t_req, t_ack, e0, w0, c0, l0, g0, acks;
        logic [1:0] got;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req  = 0; bus.ld_wr  = 0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
        for (int i = 0; i < 32; i++) memarr[i] = DW'($urandom);
        memarr[5] = 8'h3C;

        repeat (3) @(posedge Clock);
        #1;
        check("reset_owner", 32'(bus.owner), 32'(OWN_NONE));
        check("reset_rdata", 32'(bus.rdata), 32'd0);
        #1 Reset = 1'b1;

        // CPU read of address 5
        @(posedge Clock); #2;
        e0 = n_en; c0 = n_cack;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 5'd5; t_req = cyc;
        wait_ack(1'b0, 20, ok, t_ack);
        @(posedge Clock); #2 bus.cpu_req = 0;
        check("rd_ack_seen", 32'(ok), 32'd1);
        check("rd_latency",  32'(t_ack - t_req), 32'd4);
        check("rd_rdata",    32'(bus.rdata), 32'h3C);
        check("rd_en_cycles", 32'(n_en - e0), 32'd3);
        check("rd_ack_count", 32'(n_cack - c0), 32'd1);

        // Loader write of 8'hA5 to address 31
        w0 = n_we; l0 = n_lack;
        bus.ld_req = 1; bus.ld_wr = 1; bus.ld_addr = 5'd31; bus.ld_wdata = 8'hA5;
        wait_ack(1'b1, 20, ok, t_ack);
        @(posedge Clock); #2 bus.ld_req = 0;
        check("wr_ack_seen",  32'(ok), 32'd1);
        check("wr_we_cycles", 32'(n_we - w0), 32'd3);
        check("wr_addr",      32'(last_we_addr), 32'd31);
        check("wr_ack_count", 32'(n_lack - l0), 32'd1);
        check("wr_rdata_kept", 32'(bus.rdata), 32'h3C);

        // Both requesters held continuously across four accesses
        g0 = grants.size(); l0 = n_lack; acks = 0;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 5'd1;
        bus.ld_req  = 1; bus.ld_wr  = 0; bus.ld_addr  = 5'd2;
        for (int k = 0; k < 60 && acks < 4; k++) begin
            @(negedge Clock);
            if (bus.cpu_ack || bus.ld_ack) acks++;
        end
        @(posedge Clock); #2;
        bus.cpu_req = 0; bus.ld_req = 0;
        check("tie_acks", 32'(acks), 32'd4);
        for (int k = 0; k < 4; k++) begin
            got = (grants.size() > g0 + k) ? grants[g0 + k] : 2'b00;
            check($sformatf("tie_grant%0d", k), 32'(got),
                  32'((RR && (k % 2 == 1)) ? OWN_LD : OWN_CPU));
        end
        check("tie_ld_acks", 32'(n_lack - l0), RR ? 32'd2 : 32'd0);

        // CPU drops its request in the second memory cycle
        repeat (2) @(posedge Clock);
        #2;
        e0 = n_en; c0 = n_cack;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 5'd9;
        wait_owner(OWN_CPU, 10, ok);
        @(posedge Clock); #2 bus.cpu_req = 0;
        wait_ack(1'b0, 10, ok, t_ack);
        check("drop_ack_seen", 32'(ok), 32'd1);
        @(negedge Clock);
        check("drop_idle_owner", 32'(bus.owner), 32'(OWN_NONE));
        repeat (4) @(negedge Clock);
        check("drop_ack_count", 32'(n_cack - c0), 32'd1);
        check("drop_en_cycles", 32'(n_en - e0), 32'd3);
        check("drop_rdata", 32'(bus.rdata), 32'(memarr[9]));

        // Reset during a loader access, CPU pending across the reset
        @(posedge Clock); #2;
        l0 = n_lack;
        bus.ld_req = 1; bus.ld_wr = 1; bus.ld_addr = 5'd7; bus.ld_wdata = 8'h55;
        wait_owner(OWN_LD, 10, ok);
        @(posedge Clock); #2;
        Reset = 1'b0; bus.ld_req = 0;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 5'd5;
        #1;
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_owner",  32'(bus.owner), 32'(OWN_NONE));
        check("rst_rdata",  32'(bus.rdata), 32'd0);
        @(posedge Clock); #2 Reset = 1'b1;
        @(posedge Clock); @(negedge Clock);
        check("rst_regrant", 32'(bus.owner), 32'(OWN_CPU));
        wait_ack(1'b0, 10, ok, t_ack);
        @(posedge Clock); #2 bus.cpu_req = 0;
        check("rst_cpu_ack", 32'(ok), 32'd1);
        check("rst_no_ld_ack", 32'(n_lack - l0), 32'd0);
        check("rst_read", 32'(bus.rdata), 32'h3C);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clock);
            ca = bus.cpu_ack;
            la = bus.ld_ack;
            @(posedge Clock); #2;
            if (!Reset) begin
                if ($urandom_range(0, 1) == 1) Reset = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                Reset = 1'b0;
            end
            drive_req(1'b0, ca);
            drive_req(1'b1, la);
        end
        Reset = 1'b1;
        bus.cpu_req = 0; bus.ld_req = 0;
        repeat (10) @(posedge Clock);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 5, memory address width.
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 Parameter LAT, default 1, memory access length in cycles; legal range 1..15.
REQ-004 Clock  in  1  rising-edge system clock.
REQ-005 Reset  in  1  reset, asynchronous, active-low.
REQ-006 cpu_req  in  1  processor access request; held until cpu_ack.
REQ-007 cpu_wr  in  1  processor write (1) / read (0).
REQ-008 cpu_addr  in  AW  processor address.
REQ-009 cpu_wdata  in  DW  processor write data.
REQ-010 cpu_ack  out  1  one-cycle completion pulse to processor.
REQ-011 ld_req  in  1  program-loader access request; held until ld_ack.
REQ-012 ld_wr  in  1  loader write (1) / read (0).
REQ-013 ld_addr  in  AW  loader address.
REQ-014 ld_wdata  in  DW  loader write data.
REQ-015 ld_ack  out  1  one-cycle completion pulse to loader.
REQ-016 rdata  out  DW  last read data, shared by both requesters.
REQ-017 mem_en  out  1  memory enable.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_addr  out  AW  memory address.
REQ-020 mem_wdata  out  DW  memory write data.
REQ-021 mem_rdata  in  DW  memory read data, valid in last access cycle.
REQ-022 owner  out  2  current grant: 00 none, 01 CPU, 10 loader.

Function
REQ-023 FSM states IDLE, GNT_CPU, GNT_LD, ACK; one access at a time.
REQ-024 IDLE: no request -> stay; single request -> grant that requester; both -> per REQ-034/035.
REQ-025 On grant edge, wr/addr/wdata of winner are latched; later requester changes ignored until ack.
REQ-026 GNT_x lasts exactly LAT cycles: mem_en=1, mem_we=latched wr, mem_addr/mem_wdata=latched values; owner=01/10.
REQ-027 At edge ending the last GNT_x cycle: read -> rdata loaded from mem_rdata; write -> rdata unchanged; FSM -> ACK.
REQ-028 ACK lasts one cycle: matching cpu_ack/ld_ack=1, mem_en=0, owner=00, no grant made; next state IDLE.
REQ-029 Request-to-ack latency: ack asserted LAT+1 cycles after the IDLE cycle in which req was sampled.
REQ-030 Requester dropping req mid-access: access still completes and ack still pulses.
REQ-031 Outside GNT_x: mem_en=0, mem_we=0, mem_addr/mem_wdata hold last value.
REQ-032 cpu_ack and ld_ack never high simultaneously; never high outside ACK.
REQ-033 Access counter is 4 bits, counts 0..LAT-1, cleared on every grant; no wrap within an access.

Configuration
REQ-034 With ARB_ROUND_ROBIN_EN defined: simultaneous requests granted to requester not granted last; last-owner register resets to loader, so CPU wins first tie.
REQ-035 Without ARB_ROUND_ROBIN_EN: simultaneous requests always granted to CPU; no last-owner register.

Reset
REQ-036 Reset low forces immediately: state IDLE, mem_en=0, mem_we=0, cpu_ack=0, ld_ack=0, owner=00, rdata=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-037 Reset mid-access aborts the access with no ack; first grant possible in first cycle after Reset rises.

Structure
REQ-038 Package mem_arb_pkg holds state encoding, owner codes (OWN_NONE/OWN_CPU/OWN_LD) and default AW/DW.
REQ-039 No sub-module; counter and FSM inline.

Verification
REQ-040 LAT=1, CPU read addr 5, mem_rdata=8'h3C -> mem_en one cycle, cpu_ack 2 cycles after req, rdata=8'h3C.
REQ-041 LAT=3, loader write addr 31 data 8'hA5 -> mem_we high 3 cycles, mem_addr=31, ld_ack pulse once, rdata unchanged.
REQ-042 Both req held continuously, macro defined -> grants alternate CPU, LD, CPU, LD; macro undefined -> CPU only, ld_ack never.
REQ-043 CPU req dropped in second GNT cycle (LAT=3) -> access completes, cpu_ack pulses once, FSM returns IDLE.
REQ-044 Reset low in GNT_LD -> mem_en=0 and owner=00 same cycle, no ld_ack; after release, pending cpu_req granted next cycle.
